// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: state typedefs, the FIPS-197 S-box and the
// GF(2^8) helpers used by the round datapath.
package aes_pkg;

  localparam int AES_DATA_W = 128;

  typedef logic [7:0]            aes_byte_t;
  typedef logic [31:0]           aes_col_t;
  typedef logic [AES_DATA_W-1:0] aes_state_t;

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul2(input aes_byte_t b);
    return xtime(b);
  endfunction

  function automatic aes_byte_t gf_mul3(input aes_byte_t b);
    return xtime(b) ^ b;
  endfunction

  // Byte 0 sits in the top bits of the state.
  function automatic aes_byte_t state_byte(input aes_state_t s, input int idx);
    return s[AES_DATA_W-1-8*idx -: 8];
  endfunction

  function automatic aes_col_t mix_column(input aes_col_t col);
    aes_byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3,
            a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3,
            a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3),
            gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup for one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_round.sv
// Pipelined AES-128 encryption round. The accepted state and its round key are
// registered on entry, then SubBytes, ShiftRows, MixColumns and AddRoundKey
// each add one stage, so a block accepted at edge N is valid after edge N+4.
module aes_round
  import aes_pkg::*;
#(
  parameter int DATA_W = AES_DATA_W  // only 128 is meaningful
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_valid_in,
  input  logic              key_valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] round_key,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out
);

  logic       accept;
  logic       valid_in_q, valid_sub_to_shift, valid_shift_to_mix, valid_mix_to_addkey;
  aes_state_t data_in_q, data_sub_to_shift, data_shift_to_mix, data_mix_to_addkey;
  aes_state_t key_in_q, key_sub_q, key_shift_q, key_mix_q;
  aes_state_t sub_d, shift_d, mix_d;

  assign accept = data_valid_in && key_valid_in;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: data and key registers are cleared too, so data_out reads 0 straight out of reset.
      valid_in_q <= 1'b0;
      data_in_q  <= '0;
      key_in_q   <= '0;
    end else begin
      valid_in_q <= accept;
      if (accept) begin
        data_in_q <= data_in;
        key_in_q  <= round_key;
      end
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (data_in_q[AES_DATA_W-1-8*i -: 8]),
      .out_o (sub_d[AES_DATA_W-1-8*i -: 8])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_sub_to_shift <= 1'b0;
      data_sub_to_shift  <= '0;
      key_sub_q          <= '0;
    end else begin
      valid_sub_to_shift <= valid_in_q;
      if (valid_in_q) begin
        data_sub_to_shift <= sub_d;
        key_sub_q         <= key_in_q;
      end
    end
  end

  // Row r rotates left by r columns.
  always_comb begin
    // NOTE: defaulting the whole vector first keeps this block free of inferred latches.
    shift_d = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_d[AES_DATA_W-1-8*(r+4*c) -: 8] = state_byte(data_sub_to_shift, r + 4*((c + r) % 4));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_shift_to_mix <= 1'b0;
      data_shift_to_mix  <= '0;
      key_shift_q        <= '0;
    end else begin
      valid_shift_to_mix <= valid_sub_to_shift;
      if (valid_sub_to_shift) begin
        data_shift_to_mix <= shift_d;
        key_shift_q       <= key_sub_q;
      end
    end
  end

  always_comb begin
    mix_d = '0;
    for (int c = 0; c < 4; c++) begin
      mix_d[AES_DATA_W-1-32*c -: 32] = mix_column(data_shift_to_mix[AES_DATA_W-1-32*c -: 32]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_mix_to_addkey <= 1'b0;
      data_mix_to_addkey  <= '0;
      key_mix_q           <= '0;
    end else begin
      valid_mix_to_addkey <= valid_shift_to_mix;
      if (valid_shift_to_mix) begin
        data_mix_to_addkey <= mix_d;
        key_mix_q          <= key_shift_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= valid_mix_to_addkey;
      if (valid_mix_to_addkey) begin
        data_out <= data_mix_to_addkey ^ key_mix_q;
      end
    end
  end

endmodule

// File: tb/tb_aes_round.sv
// Directed bench for aes_round: FIPS-197 vectors, hand-derived MixColumns
// preimages, streaming with bubbles, handshake gating and reset behaviour.
module tb_aes_round;

  localparam logic [127:0] C1_IN   = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1_KEY  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] C1_SUB  = 128'h63cab7040953d051cd60e0e7ba70e18c;
  localparam logic [127:0] C1_SHF  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] C1_MIX  = 128'h5f72641557f5bc92f7be3b291db9f91a;
  localparam logic [127:0] C1_OUT  = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] SP_IN   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SP_SUB  = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] SP_SHF  = 128'h63fcac161bee28c3c4c193f54b8233ea;
  // Inverse ShiftRows + inverse S-box of the MixColumns test columns.
  localparam logic [127:0] MC_IN   = 128'h9fc709a70482c70909a350c7c7099468;
  localparam logic [127:0] MC_SUB  = 128'hdbc6015cf213c601010a53c6c6012245;
  localparam logic [127:0] MC_SHF  = 128'hdb135345f20a225c01010101c6c6c6c6;
  localparam logic [127:0] MC_MIX  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_valid_in, key_valid_in;
  logic [127:0] data_in, round_key;
  logic         valid_out;
  logic [127:0] data_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  aes_round dut (
    .clk           (clk),
    .reset         (reset),
    .data_valid_in (data_valid_in),
    .key_valid_in  (key_valid_in),
    .data_in       (data_in),
    .round_key     (round_key),
    .valid_out     (valid_out),
    .data_out      (data_out)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic dv, input logic kv, input logic [127:0] d, input logic [127:0] k);
    data_valid_in = dv;
    key_valid_in  = kv;
    data_in       = d;
    round_key     = k;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      tick();
      if (valid_out) n++;
    end
  endtask

  // Streaming schedule: five back-to-back blocks, bubble, block, bubble, block.
  logic         s_vld [9] = '{1, 1, 1, 1, 1, 0, 1, 0, 1};
  logic [127:0] s_dat [9] = '{C1_IN, MC_IN, '0, '1, {16{8'h01}}, '1, C1_IN, '1, MC_IN};
  logic [127:0] s_mix [9] = '{C1_MIX, MC_MIX, {16{8'h63}}, {16{8'h16}}, {16{8'h7c}}, '0, C1_MIX, '0, MC_MIX};
  logic [127:0] s_key [9] = '{C1_KEY,
                             128'h0123456789abcdeffedcba9876543210,
                             128'h000102030405060708090a0b0c0d0e0f,
                             128'ha5a5a5a55a5a5a5a3c3c3c3cc3c3c3c3,
                             128'hdeadbeefcafebabe0123456789abcdef,
                             128'hffffffffffffffffffffffffffffffff,
                             128'h0f0e0d0c0b0a09080706050403020100,
                             128'hffffffffffffffffffffffffffffffff,
                             128'h11111111111111111111111111111111};

  initial begin
    int n;

    // Reset held with live, random inputs.
    reset = 1'b1;
    repeat (3) begin
      drive(1'b1, 1'b1, rnd128(), rnd128());
      tick();
    end
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_valid_sub", dut.valid_sub_to_shift, 0);
    check("rst_valid_shift", dut.valid_shift_to_mix, 0);
    check("rst_valid_mix", dut.valid_mix_to_addkey, 0);
    check("rst_data_sub", dut.data_sub_to_shift, 0);
    idle();
    reset = 1'b0;
    tick();

    // FIPS-197 C.1 round 1, one cycle of valid input.
    drive(1'b1, 1'b1, C1_IN, C1_KEY);
    tick();
    idle();
    check("c1_vout_e0", valid_out, 0);
    tick();
    check("c1_sub", dut.data_sub_to_shift, C1_SUB);
    check("c1_vout_e1", valid_out, 0);
    tick();
    check("c1_shift", dut.data_shift_to_mix, C1_SHF);
    check("c1_vout_e2", valid_out, 0);
    tick();
    check("c1_mix", dut.data_mix_to_addkey, C1_MIX);
    check("c1_vout_e3", valid_out, 0);
    tick();
    check("c1_vout_e4", valid_out, 1);
    check("c1_out", data_out, C1_OUT);
    tick();
    check("c1_vout_e5", valid_out, 0);

    // SubBytes / ShiftRows spot check.
    drive(1'b1, 1'b1, SP_IN, '0);
    tick();
    idle();
    tick();
    check("sp_sub", dut.data_sub_to_shift, SP_SUB);
    tick();
    check("sp_shift", dut.data_shift_to_mix, SP_SHF);
    repeat (3) tick();

    // MixColumns columns with a zero key.
    drive(1'b1, 1'b1, MC_IN, '0);
    tick();
    idle();
    tick();
    check("mc_sub", dut.data_sub_to_shift, MC_SUB);
    tick();
    check("mc_shift", dut.data_shift_to_mix, MC_SHF);
    tick();
    check("mc_mix", dut.data_mix_to_addkey, MC_MIX);
    tick();
    check("mc_vout", valid_out, 1);
    check("mc_out", data_out, MC_MIX);

    // Asynchronous reset between edges while an output is showing.
    #2 reset = 1'b1;
    #1;
    check("async_vout", valid_out, 0);
    check("async_dout", data_out, 0);
    check("async_valid_mix", dut.valid_mix_to_addkey, 0);
    #3 reset = 1'b0;
    tick();

    // Streaming with bubbles and per-block keys.
    for (int t = 0; t < 13; t++) begin
      if (t < 9) drive(s_vld[t], s_vld[t] | (t % 2 == 1), s_dat[t], s_key[t]);
      else idle();
      tick();
      if (t >= 4) begin
        check($sformatf("st_vout_%0d", t - 4), valid_out, s_vld[t-4]);
        if (s_vld[t-4]) check($sformatf("st_dout_%0d", t - 4), data_out, s_mix[t-4] ^ s_key[t-4]);
      end
    end

    // Handshake: either valid alone never produces a block.
    drive(1'b1, 1'b0, C1_IN, C1_KEY);
    tick();
    drive(1'b0, 1'b1, C1_IN, C1_KEY);
    tick();
    idle();
    count_valid(8, n);
    check("hs_no_output", n, 0);

    // Reset pulse with three blocks in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, C1_IN, C1_KEY);
      tick();
    end
    idle();
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    count_valid(8, n);
    check("flush_no_output", n, 0);

    // First block after release keeps the four-edge latency.
    drive(1'b1, 1'b1, C1_IN, C1_KEY);
    tick();
    idle();
    count_valid(3, n);
    check("post_rst_early", n, 0);
    tick();
    check("post_rst_vout", valid_out, 1);
    check("post_rst_dout", data_out, C1_OUT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
